// File: rtl/axis_tid_accumulator.sv
// Per-TID AXI-Stream packet summer: one accumulator per source stream, packet sums queued in a small result FIFO.
// Optional macro AXIS_ACC_SATURATE_EN makes every accumulation saturate instead of wrapping.
module axis_tid_accumulator #(
    parameter int DATA_WIDTH        = 64,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 4,
    parameter int RESULT_DEST       = 0,
    parameter int RESULT_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    input  logic [DATA_WIDTH-1:0]     axis_in_tdata,
    input  logic                      axis_in_tlast,
    input  logic [TID_WIDTH-1:0]      axis_in_tid,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,
    output logic [DATA_WIDTH-1:0]     axis_out_tdata,
    output logic                      axis_out_tlast,
    output logic [TDEST_WIDTH-1:0]    axis_out_tdest,
    output logic [TID_WIDTH-1:0]      axis_out_tid,
    output logic [(1<<TID_WIDTH)-1:0] open_mask
);
    localparam int NUM_STREAMS = 1 << TID_WIDTH;
    localparam int PTR_W       = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam int CNT_W       = $clog2(RESULT_FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] acc_reg      [NUM_STREAMS];
    logic                  open_reg     [NUM_STREAMS];
    logic [DATA_WIDTH-1:0] fifo_data_mem[RESULT_FIFO_DEPTH];
    logic [TID_WIDTH-1:0]  fifo_tid_mem [RESULT_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      fifo_count_reg;

    logic                  in_accept;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] acc_sel;
    logic [DATA_WIDTH-1:0] sum_next;

    // Readiness depends only on buffer occupancy, never on the incoming valid.
    assign axis_in_tready = (fifo_count_reg < CNT_W'(RESULT_FIFO_DEPTH));
    assign in_accept      = axis_in_tvalid & axis_in_tready;
    assign fifo_push      = in_accept & axis_in_tlast;
    assign fifo_pop       = axis_out_tvalid & axis_out_tready;
    assign acc_sel        = acc_reg[axis_in_tid];

`ifdef AXIS_ACC_SATURATE_EN
    logic [DATA_WIDTH:0] sum_wide;
    assign sum_wide = {1'b0, acc_sel} + {1'b0, axis_in_tdata};
    // Once pinned at all-ones, further additions keep carrying out and stay pinned.
    assign sum_next = sum_wide[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_wide[DATA_WIDTH-1:0];
`else
    assign sum_next = acc_sel + axis_in_tdata;
`endif

    generate
        for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_reg[gi]  <= '0;
                    open_reg[gi] <= 1'b0;
                end else if (in_accept && (axis_in_tid == TID_WIDTH'(gi))) begin
                    if (axis_in_tlast) begin
                        acc_reg[gi]  <= '0;
                        open_reg[gi] <= 1'b0;
                    end else begin
                        acc_reg[gi]  <= sum_next;
                        open_reg[gi] <= 1'b1;
                    end
                end
            end
            assign open_mask[gi] = open_reg[gi];
        end
    endgenerate

    // Storage carries no reset; valid entries are tracked solely by the count.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_mem[wr_ptr_reg] <= sum_next;
            fifo_tid_mem[wr_ptr_reg]  <= axis_in_tid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    assign axis_out_tvalid = (fifo_count_reg != '0);
    assign axis_out_tdata  = axis_out_tvalid ? fifo_data_mem[rd_ptr_reg] : '0;
    assign axis_out_tid    = axis_out_tvalid ? fifo_tid_mem[rd_ptr_reg] : '0;
    assign axis_out_tlast  = 1'b1;
    assign axis_out_tdest  = TDEST_WIDTH'(RESULT_DEST);
endmodule

// File: tb/tb_axis_tid_accumulator.sv
// Randomized and directed bench for axis_tid_accumulator against a queue-based packet-sum model.
module tb_axis_tid_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data;
    logic [1:0]  in_tid;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_data;
    logic [3:0]  out_dest;
    logic [1:0]  out_tid;
    logic [3:0]  open_mask;

    axis_tid_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
        .axis_in_tdata(in_data), .axis_in_tlast(in_last), .axis_in_tid(in_tid),
        .axis_out_tvalid(out_valid), .axis_out_tready(out_ready),
        .axis_out_tdata(out_data), .axis_out_tlast(out_last),
        .axis_out_tdest(out_dest), .axis_out_tid(out_tid),
        .open_mask(open_mask)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] sum; logic [1:0] tid; } res_t;
    res_t        exp_q[$];
    logic [63:0] m_sum[4];
    bit          m_open[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] w;
        w = {1'b0, a} + {1'b0, b};
`ifdef AXIS_ACC_SATURATE_EN
        if (w[64]) return {64{1'b1}};
`endif
        return w[63:0];
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = m_open[i];
        return m;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin m_sum[i] = '0; m_open[i] = 0; end
    endfunction

    // One bus cycle: drive, check settled outputs against the model, apply handshakes to the model.
    task automatic step(input bit v, input logic [63:0] d, input bit l, input logic [1:0] t, input bit r);
        res_t hd;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; in_tid = t; out_ready = r;
        #1;
        chk("in_tready", 64'(in_ready), 64'(exp_q.size() < 4));
        chk("out_tvalid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("open_mask", 64'(open_mask), 64'(model_mask()));
        if (out_valid && r && exp_q.size() != 0) begin
            hd = exp_q.pop_front();
            chk("out_tdata", out_data, hd.sum);
            chk("out_tid", 64'(out_tid), 64'(hd.tid));
            chk("out_tlast", 64'(out_last), 64'd1);
            chk("out_tdest", 64'(out_dest), 64'd0);
            $display("result tid=%0d sum=%0d", out_tid, out_data);
        end
        if (v && in_ready) begin
            if (l) begin
                exp_q.push_back('{sum: add(m_sum[t], d), tid: t});
                m_sum[t] = '0; m_open[t] = 0;
            end else begin
                m_sum[t] = add(m_sum[t], d); m_open[t] = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        chk("rst_out_tdata", out_data, 64'd0);
        chk("rst_out_tid", 64'(out_tid), 64'd0);
        chk("rst_out_tlast", 64'(out_last), 64'd1);
        chk("rst_out_tdest", 64'(out_dest), 64'd0);
        chk("rst_open_mask", 64'(open_mask), 64'd0);
        chk("rst_out_tvalid", 64'(out_valid), 64'd0);
        chk("rst_in_tready", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) step(0, '0, 0, 0, 1);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        rst_n = 1'b0; in_valid = 0; in_data = '0; in_last = 0; in_tid = 0; out_ready = 0;
        model_clear();
        do_reset();

        // Sum of 1..20 on stream 0.
        for (int i = 1; i <= 20; i++) step(1, 64'(i), i == 20, 0, 1);
        step(0, '0, 0, 0, 1);
        drain();

        // Interleaved streams, stream 1 finishes first.
        step(1, 1, 0, 0, 1); step(1, 10, 0, 1, 1); step(1, 2, 0, 0, 1);
        step(1, 20, 1, 1, 1); step(1, 3, 1, 0, 1);
        drain();

        // Backpressure: four single-beat packets fill the buffer, the fifth waits.
        for (int i = 5; i <= 9; i++) step(1, 64'(i), 1, 0, 0);
        step(1, 9, 1, 0, 0);
        step(1, 9, 1, 0, 1);
        step(0, '0, 0, 0, 0);
        step(1, 9, 1, 0, 1);
        drain();

        // Reset discards a partial packet.
        step(1, 7, 0, 2, 1); step(1, 8, 0, 2, 1);
        do_reset();
        step(1, 4, 1, 2, 1);
        drain();

        // Overflow boundary.
        step(1, {64{1'b1}}, 0, 3, 1); step(1, 2, 1, 3, 1);
        drain();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            d = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end
        for (int t = 0; t < 4; t++) step(1, 0, 1, 2'(t), 1);
        drain();
        step(0, '0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_tid_accumulator.md
AXIS_TID_ACCUMULATOR -- requirements
Module: axis_tid_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: tdata width of both ports and the accumulator width.
REQ-002 SHALL have parameter TID_WIDTH, default 2: source-ID width; the block keeps 2**TID_WIDTH independent accumulators.
REQ-003 SHALL have parameter TDEST_WIDTH, default 4: destination width of the result port.
REQ-004 SHALL have parameter RESULT_DEST, default 0: constant tdest driven on every result beat.
REQ-005 SHALL have parameter RESULT_FIFO_DEPTH, default 4 (power of two, >=2): result buffer entries.
REQ-006 clk  input  1  user clock; single clock domain; every flop on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 axis_in_tvalid / axis_in_tready  input / output  1 / 1  AXIS handshake from mesh node output.
REQ-009 axis_in_tdata / axis_in_tlast / axis_in_tid  input  DATA_WIDTH / 1 / TID_WIDTH  operand, end-of-packet, source stream.
REQ-010 axis_out_tvalid / axis_out_tready  output / input  1 / 1  AXIS handshake toward mesh node input.
REQ-011 axis_out_tdata / axis_out_tlast / axis_out_tdest / axis_out_tid  output  DATA_WIDTH / 1 / TDEST_WIDTH / TID_WIDTH  result beat.
REQ-012 open_mask  output  2**TID_WIDTH  bit t = 1 while stream t has an unterminated packet.

Function
REQ-013 Input beat accepted iff axis_in_tvalid && axis_in_tready on a rising edge; nothing else changes accumulator state.
REQ-014 axis_in_tready SHALL equal (fifo_count < RESULT_FIFO_DEPTH), registered-free combinational from count; no dependence on axis_in_tvalid.
REQ-015 Per stream t, two states: IDLE (open_mask[t]=0, acc[t]=0) and ACCUM (open_mask[t]=1).
REQ-016 Accepted beat, tid=t, tlast=0: acc[t] <= acc[t] + tdata (mod 2**DATA_WIDTH); state -> ACCUM.
REQ-017 Accepted beat, tid=t, tlast=1: push sum acc[t]+tdata (mod 2**DATA_WIDTH) with tid t into result FIFO; acc[t] <= 0; state -> IDLE.
REQ-018 Single-beat packet (IDLE + tlast=1) SHALL push tdata unchanged.
REQ-019 Streams SHALL be independent; beats of different tids may interleave at beat granularity without cross-contamination.
REQ-020 Latency: tlast accepted on edge N -> axis_out_tvalid=1 after edge N when FIFO was empty (visible in cycle N+1).
REQ-021 Result beat: tdata = sum, tlast = 1, tdest = RESULT_DEST, tid = source stream; FIFO order = tlast acceptance order.
REQ-022 axis_out_* SHALL hold stable while axis_out_tvalid && !axis_out_tready.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; pop of last entry with no push -> axis_out_tvalid=0 next cycle.
REQ-024 FIFO full: axis_in_tready=0, no beat accepted (including non-tlast beats); resumes the cycle after a pop.
REQ-025 Pointers wrap modulo RESULT_FIFO_DEPTH; count range 0..RESULT_FIFO_DEPTH.

Reset
REQ-026 While rst_n=0 at an edge: all acc[t]=0, open_mask=0, FIFO count/pointers=0, axis_out_tvalid=0; axis_in_tready=1 next cycle.
REQ-027 axis_out_tdata/tid SHALL reset to 0; axis_out_tlast=1 and tdest=RESULT_DEST constant.
REQ-028 Reset mid-packet SHALL discard partial sums and buffered results; no result emitted for aborted packets.

Configuration
REQ-029 Macro AXIS_ACC_SATURATE_EN: when defined, every addition in REQ-016/017 saturates at 2**DATA_WIDTH-1 (unsigned) and stays there until the packet ends.
REQ-030 Without AXIS_ACC_SATURATE_EN, additions wrap modulo 2**DATA_WIDTH; no extra logic instantiated.

Verification
REQ-031 tid=0, tdata 1..20, tlast on 20, out_tready=1 -> one result: tdata=210, tid=0, tdest=0, tlast=1, one cycle after last beat.
REQ-032 Interleave tid0 {1,2,3} and tid1 {10,20}, tid1 ends first -> results 30 (tid1) then 6 (tid0); open_mask returns to 0.
REQ-033 out_tready=0, five single-beat packets 5,6,7,8,9 -> first four accepted, in_tready=0 at fifth; raise out_tready -> 5,6,7,8,9 in order.
REQ-034 tid2 beats 7,8 (no tlast), rst_n=0 one cycle, then tid2 single beat 4 tlast -> only result 4; open_mask=0 after reset.
REQ-035 DATA_WIDTH=64, beats 2**64-1 and 2 tlast -> result 1 without macro; 2**64-1 with AXIS_ACC_SATURATE_EN.
